i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S master receiver for the CS5343/44 ADC path. It runs on the 12.288 MHz audio clock and generates MCLK, SCLK and LRCLK toward the ADC. It deserialises the ADC's serial data into DATA_WIDTH-bit left/right samples and presents each stereo frame on a valid/ready interface to downstream audio logic.

## Interface
- DATA_WIDTH, 24: bits captured per channel; legal range 1..31.
- RATIO, 256: MCLK/LRCLK ratio; fixed at 256, other values unsupported.
- clk_i2s  in  1  12.288 MHz audio clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- rx_mclk  out  1  equals clk_i2s (combinational passthrough).
- rx_sclk  out  1  bit clock, 3.072 MHz (clk_i2s/4).
- rx_lrclk  out  1  word select, 48 kHz; 0 = left, 1 = right.
- rx_data  in  1  serial data from the ADC, driven on SCLK falling edge.
- left_sample  out  DATA_WIDTH  last completed left sample, two's complement.
- right_sample  out  DATA_WIDTH  last completed right sample.
- sample_valid  out  1  frame available.
- sample_ready  in  1  consumer accepts frame.
- overrun  out  1  sticky unread-frame-lost flag (see Configuration).
- overrun_clr  in  1  clears overrun.

## Operation
- 8-bit free-running counter ctr: reset 0, increments every clk_i2s, wraps 255→0.
- rx_sclk = ctr[1]; rx_lrclk = ctr[7]; both derived from registered counter bits, so glitch-free.
- Each half-frame has 32 slots; slot n = ctr[6:2].
- Sample point: the clk_i2s edge where ctr[1:0]==01, which coincides with the SCLK rising edge.
- Slot 0 is the I2S one-bit delay and is ignored. Slots 1..DATA_WIDTH carry MSB..LSB. Slots above DATA_WIDTH are ignored.
- Bits shift MSB-first into a DATA_WIDTH shift register.
- Left half (ctr 0..127): at left LSB sample (ctr = 4·DATA_WIDTH+1), shift result copies into a left staging register.
- Right half (ctr 128..255): at right LSB sample (ctr = 128+4·DATA_WIDTH+1), publish the frame:
  - left_sample ← staging register;
  - right_sample ← shift result;
  - sample_valid ← 1.
- Handshake:
  - Frame transfers on any cycle with sample_valid && sample_ready; sample_valid then falls next cycle.
  - Outputs are held stable while sample_valid=1 and sample_ready=0.
- Publish while sample_valid=1 and no transfer that cycle: new frame overwrites both outputs, sample_valid stays 1, overrun sets.
- Publish and transfer in the same cycle: old frame counts as accepted; new frame loads; sample_valid stays 1; no overrun.
- overrun_clr and an overrun-setting event in the same cycle: set wins.

## Timing
- Reset values:
  - ctr = 0; rx_sclk = 0; rx_lrclk = 0;
  - left_sample = 0; right_sample = 0;
  - sample_valid = 0; overrun = 0.
  - rx_mclk follows clk_i2s during reset.
- Reset mid-frame: partial shift and staging data are discarded. After release, the first valid frame is the first one whose left half begins at ctr=0.
- First publish after reset: sample_valid rises on the clk_i2s edge after the one where ctr=225 (DATA_WIDTH=24), i.e. visible while ctr=226.
- Subsequent publishes occur exactly every 256 cycles.
- Serial-to-parallel latency: last (right LSB) bit to sample_valid is 1 cycle.
- sample_ready is sampled on rising clk_i2s; no combinational path from sample_ready to any output.

## Configuration
- I2S_RX_OVERRUN_EN defined:
  - overrun is a registered sticky flag, set as described above;
  - cleared by reset_n or overrun_clr.
- Not defined:
  - overrun is tied to 0 and overrun_clr is ignored;
  - overwrite behaviour is unchanged.

## Test plan
- Clocks: run 512 cycles after reset → rx_sclk period 4 cycles, rx_lrclk period 256 cycles, 50% duty, both 0 at reset; rx_sclk rises at ctr 2, 6, …
- Basic capture: ADC model drives left 0x123456, right 0xABCDEF in I2S format, sample_ready=1 → sample_valid one cycle at ctr=226; outputs 0x123456 / 0xABCDEF.
- Backpressure: sample_ready=0 for 300 cycles, then 1 → first frame held stable; second publish overwrites with next frame; overrun=1 when macro defined, 0 otherwise; overrun_clr pulse → 0.
- Simultaneous: raise sample_ready exactly on the publish cycle → new frame loaded, sample_valid stays 1, overrun stays 0.
- Reset mid-frame: assert reset_n=0 at ctr=150 → all outputs return to reset values asynchronously; after release, the next frame decodes correctly.
- Sign/extremes: left 0x800000, right 0x7FFFFF → captured bit-exact; slots 25..31 driven 1 → ignored.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S master receiver: generates MCLK/SCLK/LRCLK (RATIO 256) and deserialises stereo samples onto a valid/ready port.
// Optional sticky overrun flag enabled by defining I2S_RX_OVERRUN_EN; otherwise overrun is tied low.
module i2s_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int RATIO      = 256
) (
    input  logic                  clk_i2s,
    input  logic                  reset_n,
    output logic                  rx_mclk,
    output logic                  rx_sclk,
    output logic                  rx_lrclk,
    input  logic                  rx_data,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int CTR_W  = $clog2(RATIO);
    localparam int SLOT_W = CTR_W - 3;
    localparam logic [CTR_W-1:0]  LEFT_LSB_CTR  = CTR_W'(4 * DATA_WIDTH + 1);
    localparam logic [CTR_W-1:0]  RIGHT_LSB_CTR = CTR_W'(RATIO / 2 + 4 * DATA_WIDTH + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(DATA_WIDTH);

    logic [CTR_W-1:0]      ctr_q, ctr_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] stage_q, stage_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH:0]   shift_ext_s;
    logic [SLOT_W-1:0]     slot_s;
    logic                  shift_en_s;
    logic                  publish_s;
    logic                  transfer_s;

    assign rx_mclk      = clk_i2s;
    assign rx_sclk      = ctr_q[1];
    assign rx_lrclk     = ctr_q[CTR_W-1];
    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;

    assign slot_s      = ctr_q[CTR_W-2:2];
    assign shift_ext_s = {shift_q, rx_data};
    assign publish_s   = (ctr_q == RIGHT_LSB_CTR);
    assign transfer_s  = valid_q && sample_ready;

    // Next-state logic: counter, deserialiser, staging and output frame.
    always_comb begin
        ctr_d      = ctr_q + CTR_W'(1);
        shift_d    = shift_q;
        stage_d    = stage_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = valid_q;
        // Slot 0 is the I2S one-bit delay; data bits sit in slots 1..DATA_WIDTH.
        shift_en_s = (ctr_q[1:0] == 2'b01) && (slot_s != {SLOT_W{1'b0}}) && (slot_s <= SLOT_LAST);
        if (shift_en_s) begin
            shift_d = shift_ext_s[DATA_WIDTH-1:0];
        end else begin
            shift_d = shift_q;
        end
        if (ctr_q == LEFT_LSB_CTR) begin
            stage_d = shift_ext_s[DATA_WIDTH-1:0];
        end else begin
            stage_d = stage_q;
        end
        if (publish_s) begin
            left_d  = stage_q;
            right_d = shift_ext_s[DATA_WIDTH-1:0];
            valid_d = 1'b1;
        end else if (transfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            ctr_q   <= {CTR_W{1'b0}};
            shift_q <= {DATA_WIDTH{1'b0}};
            stage_q <= {DATA_WIDTH{1'b0}};
            left_q  <= {DATA_WIDTH{1'b0}};
            right_q <= {DATA_WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            ctr_q   <= ctr_d;
            shift_q <= shift_d;
            stage_q <= stage_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    logic ovr_q, ovr_d;

    // A publish onto an unread frame sets the flag; setting beats clearing.
    always_comb begin
        ovr_d = ovr_q;
        if (publish_s && valid_q && !sample_ready) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Sticky overrun register.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_ovr_clr_s;

    assign unused_ovr_clr_s = overrun_clr;
    assign overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: ADC model with its own frame counter, vector table plus backpressure/reset sequences.
module tb_i2s_rx;

    logic        clk_i2s = 1'b0;
    logic        reset_n;
    logic        rx_mclk, rx_sclk, rx_lrclk;
    logic        rx_data;
    logic [23:0] left_sample, right_sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        overrun_clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_ctr = 8'd0;
    logic [23:0] cur_left  = 24'h0;
    logic [23:0] cur_right = 24'h0;
    logic        filler    = 1'b0;

`ifdef I2S_RX_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        fill;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    vec_t vecs[4];

    i2s_rx #(.DATA_WIDTH(24), .RATIO(256)) dut (
        .clk_i2s      (clk_i2s),
        .reset_n      (reset_n),
        .rx_mclk      (rx_mclk),
        .rx_sclk      (rx_sclk),
        .rx_lrclk     (rx_lrclk),
        .rx_data      (rx_data),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk_i2s = ~clk_i2s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (model ctr %0d)", name, act, exp, m_ctr);
        end
    endtask

    task automatic wait_ctr(input logic [7:0] v);
        int k;
        k = 0;
        do begin
            @(negedge clk_i2s);
            k++;
        end while (m_ctr != v && k < 600);
        if (m_ctr != v) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ctr: ctr %0d never reached, got %0d", v, m_ctr);
        end
    endtask

    task automatic set_frame(input logic [23:0] l, input logic [23:0] r, input logic f);
        wait_ctr(8'd240);
        cur_left  = l;
        cur_right = r;
        filler    = f;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_left"},  {8'h0, left_sample},  32'h0);
        chk({tag, "_right"}, {8'h0, right_sample}, 32'h0);
        chk({tag, "_valid"}, {31'h0, sample_valid}, 32'h0);
        chk({tag, "_ovr"},   {31'h0, overrun},      32'h0);
        chk({tag, "_sclk"},  {31'h0, rx_sclk},      32'h0);
        chk({tag, "_lrclk"}, {31'h0, rx_lrclk},     32'h0);
        chk({tag, "_mclk"},  {31'h0, rx_mclk},      {31'h0, clk_i2s});
    endtask

    // ADC model: independent frame counter, data changes just after the SCLK falling edge.
    initial begin
        rx_data = 1'b0;
        forever begin
            logic [23:0] w;
            int          slot;
            @(posedge clk_i2s);
            #1;
            if (!reset_n) m_ctr = 8'd0;
            else          m_ctr = m_ctr + 8'd1;
            w    = m_ctr[7] ? cur_right : cur_left;
            slot = int'(m_ctr[6:2]);
            if (slot >= 1 && slot <= 24) rx_data = w[24 - slot];
            else                         rx_data = filler;
        end
    end

    // Clock outputs against the model counter, every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk_i2s);
            if (reset_n === 1'b1) begin
                chk("sclk",  {31'h0, rx_sclk},  {31'h0, m_ctr[1]});
                chk("lrclk", {31'h0, rx_lrclk}, {31'h0, m_ctr[7]});
                chk("mclk",  {31'h0, rx_mclk},  32'h0);
            end
        end
    end

    initial begin
        vecs[0] = '{l: 24'h123456, r: 24'hABCDEF, fill: 1'b0, exp_l: 24'h123456, exp_r: 24'hABCDEF};
        vecs[1] = '{l: 24'h800000, r: 24'h7FFFFF, fill: 1'b1, exp_l: 24'h800000, exp_r: 24'h7FFFFF};
        vecs[2] = '{l: 24'h000001, r: 24'hFFFFFE, fill: 1'b1, exp_l: 24'h000001, exp_r: 24'hFFFFFE};
        vecs[3] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, fill: 1'b0, exp_l: 24'hA5A5A5, exp_r: 24'h5A5A5A};

        reset_n      = 1'b0;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        cur_left     = vecs[0].l;
        cur_right    = vecs[0].r;
        filler       = vecs[0].fill;
        repeat (3) @(negedge clk_i2s);
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // Table: one frame per vector, consumer always ready.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) set_frame(vecs[i].l, vecs[i].r, vecs[i].fill);
            wait_ctr(8'd225);
            chk("vec_valid_pre", {31'h0, sample_valid}, 32'h0);
            wait_ctr(8'd226);
            chk("vec_valid",     {31'h0, sample_valid}, 32'h1);
            chk("vec_left",      {8'h0, left_sample},   {8'h0, vecs[i].exp_l});
            chk("vec_right",     {8'h0, right_sample},  {8'h0, vecs[i].exp_r});
            chk("vec_ovr",       {31'h0, overrun},      32'h0);
            wait_ctr(8'd227);
            chk("vec_valid_post", {31'h0, sample_valid}, 32'h0);
        end

        // Backpressure: frame A held, then overwritten by frame B.
        set_frame(24'h111111, 24'h222222, 1'b0);
        sample_ready = 1'b0;
        wait_ctr(8'd226);
        chk("bp_a_valid", {31'h0, sample_valid}, 32'h1);
        chk("bp_a_left",  {8'h0, left_sample},   32'h111111);
        set_frame(24'h333333, 24'h444444, 1'b1);
        wait_ctr(8'd100);
        chk("bp_hold_valid", {31'h0, sample_valid}, 32'h1);
        chk("bp_hold_left",  {8'h0, left_sample},   32'h111111);
        chk("bp_hold_right", {8'h0, right_sample},  32'h222222);
        wait_ctr(8'd226);
        chk("bp_b_valid", {31'h0, sample_valid}, 32'h1);
        chk("bp_b_left",  {8'h0, left_sample},   32'h333333);
        chk("bp_b_right", {8'h0, right_sample},  32'h444444);
        chk("bp_ovr_set", {31'h0, overrun},      {31'h0, EXP_OVR});
        wait_ctr(8'd230);
        sample_ready = 1'b1;
        wait_ctr(8'd231);
        chk("bp_taken",    {31'h0, sample_valid}, 32'h0);
        chk("bp_ovr_hold", {31'h0, overrun},      {31'h0, EXP_OVR});
        overrun_clr = 1'b1;
        wait_ctr(8'd232);
        overrun_clr = 1'b0;
        chk("bp_ovr_clr", {31'h0, overrun}, 32'h0);

        // Simultaneous publish and transfer.
        set_frame(24'h555555, 24'h666666, 1'b0);
        wait_ctr(8'd226);
        chk("sim_c_valid", {31'h0, sample_valid}, 32'h1);
        chk("sim_c_left",  {8'h0, left_sample},   32'h555555);
        sample_ready = 1'b0;
        set_frame(24'h777777, 24'h888888, 1'b1);
        wait_ctr(8'd225);
        chk("sim_c_held", {8'h0, right_sample}, 32'h666666);
        sample_ready = 1'b1;
        wait_ctr(8'd226);
        chk("sim_d_valid", {31'h0, sample_valid}, 32'h1);
        chk("sim_d_left",  {8'h0, left_sample},   32'h777777);
        chk("sim_d_right", {8'h0, right_sample},  32'h888888);
        chk("sim_ovr",     {31'h0, overrun},      32'h0);
        wait_ctr(8'd227);
        chk("sim_d_taken", {31'h0, sample_valid}, 32'h0);

        // Reset mid-frame, then a clean frame after release.
        set_frame(24'h999999, 24'hAAAAAA, 1'b0);
        wait_ctr(8'd150);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        cur_left  = 24'hC0FFEE;
        cur_right = 24'h0BADF0;
        filler    = 1'b1;
        repeat (3) @(negedge clk_i2s);
        reset_n = 1'b1;
        wait_ctr(8'd225);
        chk("post_rst_pre", {31'h0, sample_valid}, 32'h0);
        wait_ctr(8'd226);
        chk("post_rst_valid", {31'h0, sample_valid}, 32'h1);
        chk("post_rst_left",  {8'h0, left_sample},   32'hC0FFEE);
        chk("post_rst_right", {8'h0, right_sample},  32'h0BADF0);
        wait_ctr(8'd227);
        chk("post_rst_taken", {31'h0, sample_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
